// File: rtl/washer_plant_if.sv
// Command/sensor bundle between the washing-machine controller (master) and
// the plant model (slave).
interface washer_plant_if #(
  parameter int LEVEL_W = 8
);
  // No valid/ready handshake: every command is a level sampled on each clk and
  // every sensor is a level updated on each clk, so both sides always accept.
  logic               door_lock;
  logic               motor_on;
  logic               fill_value_on;
  logic               drain_value_on;
  logic               soap_wash;
  logic               water_wash;
  logic               done;

  logic               filled;
  logic               drained;
  logic               detergent_added;
  logic               cycle_timeout;
  logic               spin_timeout;
  logic [LEVEL_W-1:0] water_level;
  logic               fault;

  modport master (
    output door_lock, motor_on, fill_value_on, drain_value_on,
           soap_wash, water_wash, done,
    input  filled, drained, detergent_added, cycle_timeout, spin_timeout,
           water_level, fault
  );

  modport slave (
    input  door_lock, motor_on, fill_value_on, drain_value_on,
           soap_wash, water_wash, done,
    output filled, drained, detergent_added, cycle_timeout, spin_timeout,
           water_level, fault
  );
endinterface

// File: rtl/washer_plant_responder.sv
// Behavioural washer plant: water-level counter, detergent dosing timer,
// wash-cycle timer and spin timer answering the controller's commands.
module washer_plant_responder #(
  parameter int LEVEL_W     = 8,
  parameter int FILL_LEVEL  = 200,
  parameter int FILL_RATE   = 4,
  parameter int DRAIN_RATE  = 5,
  parameter int DOSE_TICKS  = 16,
  parameter int CYCLE_TICKS = 1000,
  parameter int SPIN_TICKS  = 500,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  washer_plant_if.slave bus
);

  localparam logic [LEVEL_W:0]   LEVEL_MAX = {1'b0, {LEVEL_W{1'b1}}};
  localparam logic [LEVEL_W:0]   FILL_INC  = (LEVEL_W+1)'(FILL_RATE);
  localparam logic [LEVEL_W-1:0] DRAIN_DEC = LEVEL_W'(DRAIN_RATE);
  localparam logic [LEVEL_W-1:0] FILL_THR  = LEVEL_W'(FILL_LEVEL);
  localparam logic [CNT_W-1:0]   DOSE_T    = CNT_W'(DOSE_TICKS);
  localparam logic [CNT_W-1:0]   CYCLE_T   = CNT_W'(CYCLE_TICKS);
  localparam logic [CNT_W-1:0]   SPIN_T    = CNT_W'(SPIN_TICKS);

  if (FILL_LEVEL > (1 << LEVEL_W) - 1) begin : g_bad_fill_level
    $error("FILL_LEVEL does not fit in LEVEL_W bits");
  end
  if (CYCLE_TICKS > (1 << CNT_W) - 1 || SPIN_TICKS > (1 << CNT_W) - 1 ||
      DOSE_TICKS > (1 << CNT_W) - 1) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the configured tick counts");
  end

  // Registered state
  logic [LEVEL_W-1:0] level_q,    level_d;
  logic [CNT_W-1:0]   dose_cnt_q, dose_cnt_d;
  logic [CNT_W-1:0]   cyc_cnt_q,  cyc_cnt_d;
  logic [CNT_W-1:0]   spin_cnt_q, spin_cnt_d;
  logic               dosed_q,    dosed_d;
  logic               cyc_to_q,   cyc_to_d;
  logic               spin_to_q,  spin_to_d;
  logic               fault_q,    fault_d;

  // Decoded from the level register only, so no input reaches an output
  logic               filled;
  logic               drained;
  logic               dose_cond;
  logic               spin_phase;
  logic [LEVEL_W:0]   fill_sum;

  assign filled  = (level_q >= FILL_THR);
  assign drained = (level_q == '0);

  assign dose_cond  = bus.door_lock & bus.soap_wash & ~bus.water_wash &
                      ~bus.motor_on & ~bus.fill_value_on & filled;
  assign spin_phase = bus.door_lock & bus.water_wash & bus.drain_value_on &
                      drained;

  // Water level: saturating fill/drain; both valves together hold the level
  always_comb begin
    level_d  = level_q;
    fill_sum = {1'b0, level_q} + FILL_INC;
    if (bus.fill_value_on && !bus.drain_value_on) begin
      level_d = (fill_sum > LEVEL_MAX) ? LEVEL_MAX[LEVEL_W-1:0]
                                       : fill_sum[LEVEL_W-1:0];
    end else if (bus.drain_value_on && !bus.fill_value_on) begin
      level_d = (level_q < DRAIN_DEC) ? '0 : level_q - DRAIN_DEC;
    end
  end

  // Dosing: once dosed, the count freezes until done or door unlock
  always_comb begin
    dose_cnt_d = dose_cnt_q;
    dosed_d    = dosed_q;
    if (!bus.door_lock || bus.done) begin
      dose_cnt_d = '0;
      dosed_d    = 1'b0;
    end else if (!dosed_q) begin
      if (dose_cond) begin
        dose_cnt_d = dose_cnt_q + 1'b1;
        if (dose_cnt_d == DOSE_T) dosed_d = 1'b1;
      end else begin
        dose_cnt_d = '0;
      end
    end
  end

  // Wash-cycle timer saturates at CYCLE_T while the motor keeps running
  always_comb begin
    cyc_cnt_d = '0;
    cyc_to_d  = 1'b0;
    if (bus.motor_on) begin
      cyc_cnt_d = (cyc_cnt_q == CYCLE_T) ? cyc_cnt_q : cyc_cnt_q + 1'b1;
      cyc_to_d  = (cyc_cnt_d == CYCLE_T);
    end
  end

  always_comb begin
    spin_cnt_d = '0;
    spin_to_d  = 1'b0;
    if (spin_phase) begin
      spin_cnt_d = (spin_cnt_q == SPIN_T) ? spin_cnt_q : spin_cnt_q + 1'b1;
      spin_to_d  = (spin_cnt_d == SPIN_T);
    end
  end

  // Sticky illegal-command detection; never feeds back into the counters
  always_comb begin
    fault_d = fault_q;
    if ((bus.fill_value_on && bus.drain_value_on) ||
        (bus.motor_on && !bus.door_lock) ||
        (bus.fill_value_on && !bus.door_lock) ||
        (bus.motor_on && !filled)) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q    <= '0;
      dose_cnt_q <= '0;
      cyc_cnt_q  <= '0;
      spin_cnt_q <= '0;
      dosed_q    <= 1'b0;
      cyc_to_q   <= 1'b0;
      spin_to_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      level_q    <= level_d;
      dose_cnt_q <= dose_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      spin_cnt_q <= spin_cnt_d;
      dosed_q    <= dosed_d;
      cyc_to_q   <= cyc_to_d;
      spin_to_q  <= spin_to_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.filled          = filled;
  assign bus.drained         = drained;
  assign bus.detergent_added = dosed_q;
  assign bus.cycle_timeout   = cyc_to_q;
  assign bus.spin_timeout    = spin_to_q;
  assign bus.water_level     = level_q;
  assign bus.fault           = fault_q;

endmodule

// File: doc/washer_plant_responder.md
Name: washer_plant_responder

Overview:
- Behavioural plant/sensor model that answers the washing-machine controller's actuator commands with its sensor feedback. It closes the loop in simulation and on FPGA demo boards.
- Consumes the controller's door_lock, motor_on, fill_value_on, drain_value_on, soap_wash, water_wash and done.
- Produces filled, drained, detergent_added, cycle_timeout, spin_timeout and a sticky fault flag.
- Models a water-level counter, a detergent dosing timer, a wash-cycle timer and a spin timer.

Parameters:
- LEVEL_W, 8, width of water-level counter.
- FILL_LEVEL, 200, level at or above which filled asserts; must be ≤ 2^LEVEL_W-1.
- FILL_RATE, 4, level increment per clk while filling.
- DRAIN_RATE, 5, level decrement per clk while draining.
- DOSE_TICKS, 16, clks of dosing before detergent_added.
- CYCLE_TICKS, 1000, clks of motor_on before cycle_timeout.
- SPIN_TICKS, 500, clks of spin phase before spin_timeout.
- CNT_W, 16, timer width; must hold max(CYCLE_TICKS, SPIN_TICKS, DOSE_TICKS).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- door_lock  in  1  controller door lock command.
- motor_on  in  1  wash motor command.
- fill_value_on  in  1  fill valve command.
- drain_value_on  in  1  drain valve command.
- soap_wash  in  1  controller soap-phase flag.
- water_wash  in  1  controller rinse-phase flag.
- done  in  1  controller completion flag.
- filled  out  1  level ≥ FILL_LEVEL.
- drained  out  1  level == 0.
- detergent_added  out  1  dose complete.
- cycle_timeout  out  1  wash-cycle timer expired.
- spin_timeout  out  1  spin timer expired.
- water_level  out  LEVEL_W  current level, for debug.
- fault  out  1  sticky illegal-command flag.

Behaviour:
- Reset: while reset is low, asynchronously drive every register and output to 0: water_level, all timers, dosed flag, detergent_added, cycle_timeout, spin_timeout, fault, filled. drained is 1 during reset because it is decoded from level 0. Reset mid-operation aborts all timers immediately.
- All outputs are registered or decoded from registers only. No combinational input-to-output path.

Level counter, per clk:
- fill only: level += FILL_RATE, saturating at 2^LEVEL_W-1.
- drain only: level -= DRAIN_RATE, saturating at 0.
- fill and drain together: level unchanged; fault set.

Level flags:
- filled = (level ≥ FILL_LEVEL). drained = (level == 0).
- Both are level-based and follow the registered level. Latency is 1 clk from the command to the level change, and 0 further to the flag.

Dosing:
- Dose condition = door_lock & soap_wash & !water_wash & !motor_on & !fill_value_on & filled.
- The dose counter increments while the condition holds. Dropping the condition clears the counter unless dosed is already set.
- When the counter reaches DOSE_TICKS, set dosed. detergent_added = dosed, registered.
- dosed clears on done=1 or door_lock=0.

Cycle timer:
- Counts while motor_on=1; clears to 0 when motor_on=0.
- cycle_timeout asserts on the clk the count reaches CYCLE_TICKS. It holds while motor_on stays 1, with the counter saturated, and deasserts the clk after motor_on drops.

Spin timer:
- Spin phase = door_lock & water_wash & drain_value_on & drained.
- Counts while spin phase holds; clears otherwise.
- spin_timeout asserts at SPIN_TICKS and holds until the phase ends.

Fault (sticky until reset), set on any of:
- fill & drain asserted in the same clk.
- motor_on while door_lock=0.
- fill_value_on while door_lock=0.
- motor_on while level < FILL_LEVEL.

Fault effects:
- Fault never alters level or timer behaviour except the simultaneous fill/drain hold.

States:
- Implement as independent counters plus a 1-bit dosed flag. No hidden FSM.
- Equivalent phase view: IDLE → FILLING → DOSING → WASHING → DRAINING → SPINNING → IDLE.

Test Plan:
- Reset low mid-wash (level=120, cycle count=300) → next sample: water_level=0, drained=1, cycle_timeout=0, fault=0.
- fill_value_on=1, door_lock=1 for 50 clks from level 0 → filled rises on clk 50 (level=200). Level then saturates at 255 on continued fill, fault stays 0.
- Dose condition held 16 clks → detergent_added=1 at clk 16 and stays 1. Dose condition broken at clk 10, then reapplied → count restarts and detergent_added rises 16 clks after reapply.
- motor_on=1 with level=200 for 1000 clks → cycle_timeout=1 at clk 1000. motor_on low → cycle_timeout=0 next clk.
- fill and drain both 1 at level 100 → level stays 100, fault=1 and stays 1 after both drop. Separately, motor_on with door_lock=0 → fault=1.
- Full loop with controller: check_door → fill → detergent → cycle → drain → fill → cycle → drain → spin completes. done pulses once and no fault.
